// File: rtl/regfile_pkg.sv
// Shared constants for the 2-read / 1-write register file.
// Imported by the storage cell and the register-file top.
package regfile_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_DEPTH    = 32;
  localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/rf_register.sv
// Single storage entry: clock-enabled register with async clear.
// Instantiated once per writable register-file entry.
module rf_register
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file, two combinational reads, one clocked write.
// Entry 0 reads as zero; counts accepted writes with saturation.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter bit BYPASS = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic [CNT_W-1:0]  WriteCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] wr_sel;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd1_raw;
  logic [WIDTH-1:0] rd2_raw;
  logic             hit1;
  logic             hit2;
  logic             accepted;

  // One-hot write decode; entry 0 can never be selected.
  always_comb begin
    wr_sel = '0;
    if (RegWrite && !Reset) begin
      wr_sel[WriteRegister] = 1'b1;
    end
    wr_sel[RF_ZERO_REG] = 1'b0;
  end

  assign regs[RF_ZERO_REG] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    rf_register #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk(Clk),
      .rst(Reset),
      .en (wr_sel[i]),
      .d  (WriteData),
      .q  (regs[i])
    );
  end

  assign rd1_raw = regs[ReadRegister1];
  assign rd2_raw = regs[ReadRegister2];

  if (BYPASS) begin : g_bypass
    assign hit1 = RegWrite
                  && (ReadRegister1 == WriteRegister)
                  && (ReadRegister1 != '0);
    assign hit2 = RegWrite
                  && (ReadRegister2 == WriteRegister)
                  && (ReadRegister2 != '0);
  end else begin : g_no_bypass
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
  end

  // Reset masks the bypass path so reads are zero throughout reset.
  always_comb begin
    ReadData1 = rd1_raw;
    ReadData2 = rd2_raw;
    if (Reset) begin
      ReadData1 = '0;
      ReadData2 = '0;
    end else begin
      if (hit1) ReadData1 = WriteData;
      if (hit2) ReadData2 = WriteData;
    end
  end

  assign accepted = |wr_sel;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WriteCount <= '0;
    end else if (accepted && (WriteCount != '1)) begin
      WriteCount <= WriteCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: a non-bypass and a bypass
// instance share stimulus and are checked against a reference model.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  rr1;
  logic [4:0]  rr2;
  logic [31:0] rd1_n;
  logic [31:0] rd2_n;
  logic [31:0] rd1_b;
  logic [31:0] rd2_b;
  logic [15:0] cnt_n;
  logic [3:0]  cnt_b;

  regfile_2r1w #(
    .WIDTH (32),
    .ADDR_W(5),
    .BYPASS(1'b0),
    .CNT_W (16)
  ) dut_n (
    .Clk          (clk),
    .Reset        (rst),
    .RegWrite     (we),
    .WriteRegister(wa),
    .WriteData    (wd),
    .ReadRegister1(rr1),
    .ReadRegister2(rr2),
    .ReadData1    (rd1_n),
    .ReadData2    (rd2_n),
    .WriteCount   (cnt_n)
  );

  regfile_2r1w #(
    .WIDTH (32),
    .ADDR_W(5),
    .BYPASS(1'b1),
    .CNT_W (4)
  ) dut_b (
    .Clk          (clk),
    .Reset        (rst),
    .RegWrite     (we),
    .WriteRegister(wa),
    .WriteData    (wd),
    .ReadRegister1(rr1),
    .ReadRegister2(rr2),
    .ReadData1    (rd1_b),
    .ReadData2    (rd2_b),
    .WriteCount   (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] val;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem [32];
  int unsigned cnt0;
  int unsigned cnt1;
  int          nvec;
  int          nerr;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int src);
    case (src)
      0:       return rd1_n;
      1:       return rd2_n;
      2:       return rd1_b;
      3:       return rd2_b;
      4:       return {16'h0, cnt_n};
      default: return {28'h0, cnt_b};
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input bit byp,
                                         input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (byp && we && a == wa) return wd;
    return mem[a];
  endfunction

  task automatic push(input string tag, input int src,
                      input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check_eq(e.tag, observe(e.src), e.val);
    end
  endtask

  task automatic expect_all(input string tag);
    #1;
    push({tag, "/n1"}, 0, exp_rd(1'b0, rr1));
    push({tag, "/n2"}, 1, exp_rd(1'b0, rr2));
    push({tag, "/b1"}, 2, exp_rd(1'b1, rr1));
    push({tag, "/b2"}, 3, exp_rd(1'b1, rr2));
    push({tag, "/cn"}, 4, cnt0);
    push({tag, "/cb"}, 5, cnt1);
    drain();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    cnt0 = 0;
    cnt1 = 0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                          input logic en);
    @(negedge clk);
    we = en;
    wa = a;
    wd = d;
    @(posedge clk);
    #1;
    if (en && a != 5'd0) begin
      mem[a] = d;
      if (cnt0 < 65535) cnt0++;
      if (cnt1 < 15) cnt1++;
    end
    we = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
    rr1 = a1;
    rr2 = a2;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    model_clear();
    rst = 1'b1;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;
    rr1 = 5'd1;
    rr2 = 5'd31;
    repeat (2) @(posedge clk);
    expect_all("reset");
    @(negedge clk);
    rst = 1'b0;
    expect_all("post_reset");

    // Basic write and dual read of the same address
    set_rd(5'd2, 5'd2);
    do_write(5'd2, 32'd42, 1'b1);
    expect_all("t1_w42");

    // Disabled write must not disturb contents
    do_write(5'd2, 32'd15, 1'b1);
    do_write(5'd2, 32'd99, 1'b0);
    expect_all("t2_we0");

    // Neighbouring and aliasing addresses stay zero
    set_rd(5'd3, 5'd4);
    expect_all("t3_nbr");
    do_write(5'd14, 32'd15, 1'b1);
    set_rd(5'd14, 5'd4);
    expect_all("t3_alias");

    // Writes to r0 are dropped and not counted
    set_rd(5'd0, 5'd2);
    do_write(5'd0, 32'hDEADBEEF, 1'b1);
    expect_all("t4_r0");

    // Async reset between edges kills a pending write
    set_rd(5'd5, 5'd2);
    do_write(5'd5, 32'd7, 1'b1);
    expect_all("t5_w7");
    @(negedge clk);
    we = 1'b1;
    wa = 5'd5;
    wd = 32'd9;
    #2;
    rst = 1'b1;
    model_clear();
    expect_all("t5_async");
    @(posedge clk);
    expect_all("t5_held");
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    do_write(5'd5, 32'd9, 1'b1);
    expect_all("t5_after");

    // Same-cycle read of the write target
    do_write(5'd8, 32'h55, 1'b1);
    @(negedge clk);
    set_rd(5'd8, 5'd8);
    we = 1'b1;
    wa = 5'd8;
    wd = 32'h1234;
    expect_all("t6_pre");
    @(posedge clk);
    #1;
    mem[8] = 32'h1234;
    if (cnt0 < 65535) cnt0++;
    if (cnt1 < 15) cnt1++;
    we = 1'b0;
    expect_all("t6_post");
    @(negedge clk);
    set_rd(5'd0, 5'd0);
    we = 1'b1;
    wa = 5'd0;
    wd = 32'hFFFF_FFFF;
    expect_all("t6_r0");
    we = 1'b0;

    // Random traffic; also drives the 4-bit counter into saturation
    for (int i = 0; i < 40; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      do_write(a, $urandom, 1'($urandom_range(0, 3) != 0));
      set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      expect_all("rand");
    end

    // Fill every entry with a distinct pattern and sweep both ports
    for (int i = 0; i < 32; i++) begin
      do_write(5'(i), 32'hA5000000 | 32'(i * 32'h01010101), 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      expect_all("sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
